sc_generator_obstacle_rows: RTL and testbench
=============================================

Name: sc_generator_obstacle_rows

Overview:
- Parametrised successor of the single-byte environment generator; produces one WIDTH-lane obstacle row per road-scroll tick.
- Obstacle density and the spacing between obstacle rows depend on the 2-bit game level.
- Every non-empty row is guaranteed at least one free lane, so the road is always passable.
- Sits between the game-control FSM (start, level, scroll tick) and the road/obstacle rendering memory.

Parameters:
- WIDTH, 8, number of lanes per row; legal range 2..10.
- LFSR_W, 32, LFSR register width; must be >= 3*WIDTH.
- TAPS, 32'h80200003, Galois feedback mask; the default gives maximal length for 32 bits.
- SEED, 32'h1ACE_B00C, LFSR reset value; a zero value is replaced by 1.
- CNT_W, 16, width of the row counter.

Ports:
- SC_GENERATOR_OBSTACLE_ROWS_CLOCK_50  in  1  system clock; all logic on its rising edge.
- SC_GENERATOR_OBSTACLE_ROWS_RESET_InHigh  in  1  synchronous reset, active-high.
- SC_GENERATOR_OBSTACLE_ROWS_START_InLow  in  1  start request, active-low level.
- SC_GENERATOR_OBSTACLE_ROWS_STOP_InLow  in  1  stop request, active-low level.
- SC_GENERATOR_OBSTACLE_ROWS_DOWN_InLow  in  1  scroll strobe; a 1->0 transition is one tick.
- SC_GENERATOR_OBSTACLE_ROWS_LEVEL_InBus  in  2  difficulty level 0..3.
- SC_GENERATOR_OBSTACLE_ROWS_Row_OutBus  out  WIDTH  current row; bit i=1 means lane i is blocked.
- SC_GENERATOR_OBSTACLE_ROWS_RowValid_Out  out  1  one-cycle pulse when a new row is presented.
- SC_GENERATOR_OBSTACLE_ROWS_RowCount_OutBus  out  CNT_W  number of rows emitted since start.
- SC_GENERATOR_OBSTACLE_ROWS_Running_Out  out  1  high while in RUN.

Behaviour:
- Reset is synchronous and active-high; it overrides all other inputs, including mid-run. On reset:
  - Row = 0, RowValid = 0, RowCount = 0, Running = 0.
  - State = IDLE; LFSR = SEED (1 if SEED = 0); gap = 0; free-lane pointer = 0.
  - down_d = 1.
- LFSR: Galois, shifts right every cycle in all states. If lsb = 1, the next value is (lfsr>>1)^TAPS, otherwise lfsr>>1. Slices: r0 = lfsr[WIDTH-1:0], r1 = next WIDTH bits, r2 = next WIDTH bits.
- Tick: down_d is a registered copy of DOWN_InLow. tick = down_d & ~DOWN_InLow, so one tick per falling edge no matter how long the strobe stays low.
- FSM states: IDLE, RUN.
  - IDLE -> RUN when START_InLow = 0. On entry, RowCount, gap and pointer clear; Row is unchanged.
  - RUN -> IDLE when STOP_InLow = 0. Running drops the next cycle and ticks are ignored in IDLE.
  - START and STOP low together: STOP wins; the block stays in or returns to IDLE.
  - START while already in RUN is ignored.
- Row generation, on a tick in RUN; LEVEL is sampled in the tick cycle:
  - If gap > 0: candidate = 0 and gap decrements.
  - Otherwise candidate by level:
    - L0: r0 & r1 & r2
    - L1: r0 & r1
    - L2 and L3: r0
  - If the candidate is non-zero, gap loads 3/2/1/0 for L0/L1/L2/L3.
  - Full-row override: if the candidate is all ones, bit[pointer] is cleared.
  - Pointer increments on every emitted row and wraps WIDTH-1 -> 0.
- Latency: tick in cycle n gives Row, RowValid = 1 and RowCount+1 registered at edge n+1.
  - Row holds until the next emitted row.
  - RowValid is 0 in every other cycle.
  - RowCount wraps at 2^CNT_W-1 -> 0.
- A tick in the same cycle as STOP is dropped.

Test Plan:
- Reset then idle: hold RESET 3 cycles, toggle DOWN 5 times with START high -> Row = 0, RowValid never asserts, RowCount = 0, Running = 0.
- Start, L2, 4 ticks 10 cycles apart -> 4 RowValid pulses each exactly 1 cycle, at tick+1. Each Row equals the reference-model r0 of the tick cycle with the gap rule applied. RowCount = 4.
- Gap rule at L0 with a forced non-zero row -> the next 3 ticks give Row = 0. The 4th row is again r0&r1&r2. Switch to L3 -> no empty rows are inserted.
- WIDTH = 2, L3, 200 ticks -> Row never equals 2'b11. Each time the model's candidate is 11, the cleared bit equals the pointer value.
- DOWN held low 50 cycles, then high 1 cycle, then low -> exactly 2 rows emitted. START and STOP low together from IDLE -> Running stays 0.
- Reset asserted mid-run after 7 rows -> next cycle all outputs are at reset values and the LFSR equals SEED. Re-start then reproduces the identical row sequence when ticks arrive on the same cycle offsets.

Source files
------------

// File: rtl/sc_generator_obstacle_rows.sv
// Obstacle-row generator: a free-running Galois LFSR feeds WIDTH-lane rows on each
// scroll tick. Density and spacing follow the level, and every full row keeps one lane open.

module sc_gor_lane (
  input  logic       i_r0,
  input  logic       i_r1,
  input  logic       i_r2,
  input  logic [1:0] i_level,
  input  logic       i_gap_zero,
  output logic       o_cand
);
  always_comb begin
    o_cand = 1'b0;
    if (i_gap_zero) begin
      case (i_level)
        2'd0:    o_cand = i_r0 & i_r1 & i_r2;
        2'd1:    o_cand = i_r0 & i_r1;
        default: o_cand = i_r0;
      endcase
    end
  end
endmodule

module sc_generator_obstacle_rows #(
  parameter int                WIDTH  = 8,
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] TAPS   = 32'h80200003,
  parameter logic [LFSR_W-1:0] SEED   = 32'h1ACE_B00C,
  parameter int                CNT_W  = 16
) (
  input  logic             SC_GENERATOR_OBSTACLE_ROWS_CLOCK_50,
  input  logic             SC_GENERATOR_OBSTACLE_ROWS_RESET_InHigh,
  input  logic             SC_GENERATOR_OBSTACLE_ROWS_START_InLow,
  input  logic             SC_GENERATOR_OBSTACLE_ROWS_STOP_InLow,
  input  logic             SC_GENERATOR_OBSTACLE_ROWS_DOWN_InLow,
  input  logic [1:0]       SC_GENERATOR_OBSTACLE_ROWS_LEVEL_InBus,
  output logic [WIDTH-1:0] SC_GENERATOR_OBSTACLE_ROWS_Row_OutBus,
  output logic             SC_GENERATOR_OBSTACLE_ROWS_RowValid_Out,
  output logic [CNT_W-1:0] SC_GENERATOR_OBSTACLE_ROWS_RowCount_OutBus,
  output logic             SC_GENERATOR_OBSTACLE_ROWS_Running_Out
);
  localparam int                PW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [LFSR_W-1:0] SEED_NZ = (SEED == '0) ? LFSR_W'(1) : SEED;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            r_state;
  logic [LFSR_W-1:0] r_lfsr, w_lfsr_nxt;
  logic              r_down_d, w_tick;
  logic [1:0]        r_gap;
  logic [PW-1:0]     r_ptr, w_ptr_nxt;
  logic [WIDTH-1:0]  w_cand, w_row, r_row;
  logic              w_full, w_gap_zero;
  logic              r_valid, r_running;
  logic [CNT_W-1:0]  r_cnt;

  assign w_lfsr_nxt = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);
  assign w_tick     = r_down_d & ~SC_GENERATOR_OBSTACLE_ROWS_DOWN_InLow;
  assign w_gap_zero = (r_gap == 2'd0);
  assign w_full     = &w_cand;
  assign w_ptr_nxt  = (r_ptr == PW'(WIDTH-1)) ? '0 : r_ptr + 1'b1;

  // Lane i draws from bit i of each of the three low LFSR slices.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sc_gor_lane u_lane (
      .i_r0      (r_lfsr[i]),
      .i_r1      (r_lfsr[WIDTH+i]),
      .i_r2      (r_lfsr[2*WIDTH+i]),
      .i_level   (SC_GENERATOR_OBSTACLE_ROWS_LEVEL_InBus),
      .i_gap_zero(w_gap_zero),
      .o_cand    (w_cand[i])
    );
    assign w_row[i] = w_cand[i] & ~(w_full && (r_ptr == PW'(i)));
  end

  always_ff @(posedge SC_GENERATOR_OBSTACLE_ROWS_CLOCK_50) begin
    if (SC_GENERATOR_OBSTACLE_ROWS_RESET_InHigh) begin
      r_state   <= IDLE;
      r_lfsr    <= SEED_NZ;
      r_down_d  <= 1'b1;
      r_gap     <= '0;
      r_ptr     <= '0;
      r_row     <= '0;
      r_valid   <= 1'b0;
      r_cnt     <= '0;
      r_running <= 1'b0;
    end else begin
      r_lfsr   <= w_lfsr_nxt;
      r_down_d <= SC_GENERATOR_OBSTACLE_ROWS_DOWN_InLow;
      r_valid  <= 1'b0;
      case (r_state)
        IDLE: begin
          // STOP dominates a simultaneous START.
          if (SC_GENERATOR_OBSTACLE_ROWS_STOP_InLow && !SC_GENERATOR_OBSTACLE_ROWS_START_InLow) begin
            r_state   <= RUN;
            r_running <= 1'b1;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_ptr     <= '0;
          end
        end
        RUN: begin
          if (!SC_GENERATOR_OBSTACLE_ROWS_STOP_InLow) begin
            r_state   <= IDLE;
            r_running <= 1'b0;
          end else if (w_tick) begin
            r_row   <= w_row;
            r_valid <= 1'b1;
            r_cnt   <= r_cnt + 1'b1;
            r_ptr   <= w_ptr_nxt;
            if (!w_gap_zero)
              r_gap <= r_gap - 1'b1;
            else if (|w_cand)
              r_gap <= 2'd3 - SC_GENERATOR_OBSTACLE_ROWS_LEVEL_InBus;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign SC_GENERATOR_OBSTACLE_ROWS_Row_OutBus      = r_row;
  assign SC_GENERATOR_OBSTACLE_ROWS_RowValid_Out    = r_valid;
  assign SC_GENERATOR_OBSTACLE_ROWS_RowCount_OutBus = r_cnt;
  assign SC_GENERATOR_OBSTACLE_ROWS_Running_Out     = r_running;
endmodule

// File: tb/tb_sc_generator_obstacle_rows.sv
// Scoreboard bench: a reference model drives expected rows for WIDTH=8 and WIDTH=2 instances.
module tb_sc_generator_obstacle_rows;
  logic       clk = 1'b0;
  logic       rst, start, stop, down;
  logic [1:0] level;
  logic [7:0] row8;  logic v8, run8; logic [15:0] cnt8;
  logic [1:0] row2;  logic v2, run2; logic [15:0] cnt2;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  sc_generator_obstacle_rows u_dut8 (
    .SC_GENERATOR_OBSTACLE_ROWS_CLOCK_50       (clk),
    .SC_GENERATOR_OBSTACLE_ROWS_RESET_InHigh   (rst),
    .SC_GENERATOR_OBSTACLE_ROWS_START_InLow    (start),
    .SC_GENERATOR_OBSTACLE_ROWS_STOP_InLow     (stop),
    .SC_GENERATOR_OBSTACLE_ROWS_DOWN_InLow     (down),
    .SC_GENERATOR_OBSTACLE_ROWS_LEVEL_InBus    (level),
    .SC_GENERATOR_OBSTACLE_ROWS_Row_OutBus     (row8),
    .SC_GENERATOR_OBSTACLE_ROWS_RowValid_Out   (v8),
    .SC_GENERATOR_OBSTACLE_ROWS_RowCount_OutBus(cnt8),
    .SC_GENERATOR_OBSTACLE_ROWS_Running_Out    (run8)
  );

  sc_generator_obstacle_rows #(.WIDTH(2)) u_dut2 (
    .SC_GENERATOR_OBSTACLE_ROWS_CLOCK_50       (clk),
    .SC_GENERATOR_OBSTACLE_ROWS_RESET_InHigh   (rst),
    .SC_GENERATOR_OBSTACLE_ROWS_START_InLow    (start),
    .SC_GENERATOR_OBSTACLE_ROWS_STOP_InLow     (stop),
    .SC_GENERATOR_OBSTACLE_ROWS_DOWN_InLow     (down),
    .SC_GENERATOR_OBSTACLE_ROWS_LEVEL_InBus    (level),
    .SC_GENERATOR_OBSTACLE_ROWS_Row_OutBus     (row2),
    .SC_GENERATOR_OBSTACLE_ROWS_RowValid_Out   (v2),
    .SC_GENERATOR_OBSTACLE_ROWS_RowCount_OutBus(cnt2),
    .SC_GENERATOR_OBSTACLE_ROWS_Running_Out    (run2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_lfsr = 32'h1ACE_B00C;
  logic        m_run = 1'b0, m_dd = 1'b1;
  logic [15:0] m_cnt = '0;
  int          m_gap[2], m_ptr[2];
  logic [7:0]  q8[$], q2[$];

  task automatic m_emit(input int k, input int w);
    logic [31:0] mask, r0, r1, r2, c;
    mask = (32'd1 << w) - 1;
    r0 = m_lfsr & mask;
    r1 = (m_lfsr >> w) & mask;
    r2 = (m_lfsr >> (2*w)) & mask;
    if (m_gap[k] > 0) begin
      c = 0;
      m_gap[k]--;
    end else begin
      case (level)
        2'd0:    c = r0 & r1 & r2;
        2'd1:    c = r0 & r1;
        default: c = r0;
      endcase
      if (c != 0) m_gap[k] = 3 - int'(level);
    end
    if (c == mask) c = c & ~(32'd1 << m_ptr[k]);
    m_ptr[k] = (m_ptr[k] + 1) % w;
    if (k == 0) q8.push_back(c[7:0]); else q2.push_back(c[7:0]);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_lfsr = 32'h1ACE_B00C; m_run = 0; m_dd = 1; m_cnt = 0;
      m_gap[0] = 0; m_gap[1] = 0; m_ptr[0] = 0; m_ptr[1] = 0;
      q8.delete(); q2.delete();
    end else begin
      if (!m_run) begin
        if (stop && !start) begin
          m_run = 1; m_cnt = 0;
          m_gap[0] = 0; m_gap[1] = 0; m_ptr[0] = 0; m_ptr[1] = 0;
        end
      end else if (!stop) begin
        m_run = 0;
      end else if (m_dd && !down) begin
        m_emit(0, 8);
        m_emit(1, 2);
        m_cnt++;
      end
      m_dd   = down;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h80200003) : (m_lfsr >> 1);
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         nv8 = 0, nz_rows = 0, z_rows = 0;
  logic       rec_en = 1'b0;
  logic [7:0] rec[$];

  always @(negedge clk) begin
    logic [7:0] e;
    chk("valid8", 32'(v8), 32'(q8.size() != 0));
    chk("valid2", 32'(v2), 32'(q2.size() != 0));
    if (q8.size() != 0) begin
      e = q8.pop_front();
      chk("row8", 32'(row8), 32'(e));
      chk("cnt8", 32'(cnt8), 32'(m_cnt));
    end
    if (q2.size() != 0) begin
      e = q2.pop_front();
      chk("row2", 32'(row2), 32'(e));
      chk("cnt2", 32'(cnt2), 32'(m_cnt));
    end
    if (v2) chk("row2_passable", 32'(row2 == 2'b11), 32'd0);
    chk("run8", 32'(run8), 32'(m_run));
    chk("run2", 32'(run2), 32'(m_run));
    if (v8) begin
      nv8++;
      if (row8 != 0) nz_rows++; else z_rows++;
      if (rec_en) rec.push_back(row8);
    end
  end

  // ---------------- stimulus ----------------
  task automatic pulse_down(input int sp);
    down = 1'b0;
    @(negedge clk);
    down = 1'b1;
    repeat (sp - 1) @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_rec(output logic [7:0] rows[$]);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_row8", 32'(row8), 0);
    chk("rst_valid8", 32'(v8), 0);
    chk("rst_cnt8", 32'(cnt8), 0);
    chk("rst_run8", 32'(run8), 0);
    @(negedge clk);
    rst = 1'b0;
    rec.delete();
    rec_en = 1'b1;
    do_start();
    level = 2'd1;
    repeat (7) pulse_down(5);
    rec_en = 1'b0;
    rows = rec;
  endtask

  logic [7:0] rec_a[$], rec_b[$];
  int base, nz0, z0;

  initial begin
    rst = 1'b1; start = 1'b1; stop = 1'b1; down = 1'b1; level = 2'd2;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle: ticks ignored
    repeat (5) pulse_down(2);
    chk("idle_row", 32'(row8), 0);
    chk("idle_cnt", 32'(cnt8), 0);
    chk("idle_run", 32'(run8), 0);
    chk("idle_pulses", 32'(nv8), 0);

    // L2, four spaced ticks
    do_start();
    chk("start_run", 32'(run8), 1);
    level = 2'd2;
    base = nv8;
    repeat (4) pulse_down(10);
    chk("l2_pulses", 32'(nv8 - base), 4);
    chk("l2_cnt", 32'(cnt8), 4);

    // L0: gap rule must produce both blocked and empty rows
    level = 2'd0;
    nz0 = nz_rows; z0 = z_rows;
    repeat (60) pulse_down(3);
    chk("l0_nonzero_seen", 32'(nz_rows > nz0), 1);
    chk("l0_empty_seen", 32'(z_rows > z0), 1);

    // L3: no gaps, many full-row overrides on the WIDTH=2 instance
    level = 2'd3;
    repeat (200) pulse_down(2);

    // DOWN held low: one tick per falling edge
    base = nv8;
    down = 1'b0;
    repeat (50) @(negedge clk);
    down = 1'b1;
    @(negedge clk);
    down = 1'b0;
    repeat (5) @(negedge clk);
    down = 1'b1;
    repeat (2) @(negedge clk);
    chk("hold_rows", 32'(nv8 - base), 2);

    // Stop, tick coincident with STOP is dropped
    base = nv8;
    stop = 1'b0; down = 1'b0;
    @(negedge clk);
    stop = 1'b1; down = 1'b1;
    repeat (2) @(negedge clk);
    chk("stop_run", 32'(run8), 0);
    chk("stop_tick_dropped", 32'(nv8 - base), 0);

    // START and STOP together from IDLE
    start = 1'b0; stop = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    chk("both_low_run", 32'(run8), 0);

    // Reset mid-run reproduces the sequence
    run_rec(rec_a);
    run_rec(rec_b);
    chk("rec_len", 32'(rec_b.size()), 32'(rec_a.size()));
    chk("rec_len7", 32'(rec_a.size()), 7);
    for (int i = 0; i < rec_a.size() && i < rec_b.size(); i++)
      chk("rec_row", 32'(rec_b[i]), 32'(rec_a[i]));

    repeat (3) @(negedge clk);
    chk("q8_drained", 32'(q8.size()), 0);
    chk("q2_drained", 32'(q2.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
